// File: rtl/usg_pkt_pkg.sv
// Shared constants and types for the USG packet pipeline.
package usg_pkt_pkg;

  // FAST2.0 packet word width; the top two bits carry the word tag
  localparam int unsigned w_pkt = 134;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam int unsigned HIGH_WATER_DEFAULT = 200;
  localparam int unsigned VF_AW_DEFAULT      = 4;

  // Data FIFO geometry
  localparam int unsigned DFIFO_AW    = 8;
  localparam int unsigned DFIFO_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_134_256.sv
// First-word-fall-through packet FIFO, 256 entries, synchronous clear.
module fifo_134_256
  import usg_pkt_pkg::*;
#(
  parameter int unsigned width = w_pkt
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                wr_en,
  input  logic [width-1:0]    din,
  input  logic                rd_en,
  output logic [width-1:0]    dout,
  output logic [DFIFO_AW-1:0] data_count
);

  localparam int unsigned CW = DFIFO_AW + 1;

  logic [width-1:0]    mem [DFIFO_DEPTH];
  logic [DFIFO_AW-1:0] wr_ptr;
  logic [DFIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full  = (count == CW'(DFIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Head word is always visible on dout
  assign dout = mem[rd_ptr];

  // Occupancy saturates at all-ones when the array is completely full
  assign data_count = full ? '1 : count[DFIFO_AW-1:0];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DFIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + DFIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pkt_commit_buffer.sv
// Holds packets until their commit verdict arrives, then forwards or drops them.
module pkt_commit_buffer #(
  parameter int unsigned w_pkt      = usg_pkt_pkg::w_pkt,
  parameter int unsigned VF_AW      = usg_pkt_pkg::VF_AW_DEFAULT,
  parameter int unsigned HIGH_WATER = usg_pkt_pkg::HIGH_WATER_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pktin_data_wr,
  input  logic [w_pkt-1:0] pktin_data,
  input  logic             pktin_valid_wr,
  input  logic             pktin_valid,
  output logic             pktin_ready,
  output logic             pktout_data_wr,
  output logic [w_pkt-1:0] pktout_data,
  input  logic             pktout_ready,
  output logic [31:0]      fwd_cnt,
  output logic [31:0]      drop_cnt
);

  import usg_pkt_pkg::*;

  localparam int unsigned VF_DEPTH = 2 ** VF_AW;
  localparam int unsigned VF_CW    = VF_AW + 1;

  state_t               state;
  logic [VF_DEPTH-1:0]  vf_mem;
  logic [VF_AW-1:0]     vf_wr_ptr;
  logic [VF_AW-1:0]     vf_rd_ptr;
  logic [VF_CW-1:0]     vf_count;
  logic                 vf_head;
  logic                 vf_push;
  logic                 vf_pop;
  logic                 rd_en;
  logic                 tail_c;
  logic [w_pkt-1:0]     dout;
  logic [DFIFO_AW-1:0]  data_count;

  fifo_134_256 #(
    .width(w_pkt)
  ) u_data_fifo (
    .clk       (clk),
    .srst      (!reset),
    .wr_en     (pktin_data_wr),
    .din       (pktin_data),
    .rd_en     (rd_en),
    .dout      (dout),
    .data_count(data_count)
  );

  assign vf_head = vf_mem[vf_rd_ptr];
  assign vf_push = pktin_valid_wr && (vf_count != VF_CW'(VF_DEPTH));
  // A drop verdict is consumed regardless of downstream readiness
  assign vf_pop  = (state == ST_IDLE) && (vf_count != '0) && (!vf_head || pktout_ready);
  assign rd_en   = (state == ST_SEND) || (state == ST_DISCARD);
  assign tail_c  = (dout[w_pkt-1 -: 2] == TAG_TAIL);

  // Verdict FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vf_wr_ptr <= '0;
      vf_rd_ptr <= '0;
      vf_count  <= '0;
    end else begin
      if (vf_push) vf_wr_ptr <= vf_wr_ptr + VF_AW'(1);
      if (vf_pop)  vf_rd_ptr <= vf_rd_ptr + VF_AW'(1);
      case ({vf_push, vf_pop})
        2'b10:   vf_count <= vf_count + VF_CW'(1);
        2'b01:   vf_count <= vf_count - VF_CW'(1);
        default: vf_count <= vf_count;
      endcase
    end
  end

  // Verdict FIFO storage
  always_ff @(posedge clk) begin
    if (vf_push) vf_mem[vf_wr_ptr] <= pktin_valid;
  end

  // Upstream flow control from data and verdict occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pktin_ready <= 1'b1;
    end else begin
      pktin_ready <= (32'(data_count) < HIGH_WATER) && (vf_count < VF_CW'(14));
    end
  end

  // Packet dispatch FSM with registered output word and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      pktout_data_wr <= 1'b0;
      pktout_data    <= '0;
      fwd_cnt        <= '0;
      drop_cnt       <= '0;
    end else begin
      pktout_data_wr <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (vf_pop) state <= vf_head ? ST_SEND : ST_DISCARD;
        end
        ST_SEND: begin
          pktout_data_wr <= 1'b1;
          pktout_data    <= dout;
          if (tail_c) begin
            fwd_cnt <= fwd_cnt + 32'd1;
            state   <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (tail_c) begin
            drop_cnt <= drop_cnt + 32'd1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
